stencil_seq: RTL and testbench
==============================

# stencil_seq

Row-level sequencer for the stencil coprocessor. It sits between the AXI-lite register block, which supplies GO/SIZE/SRC/DST and reads back DONE, and the stencil datapath. It walks an N×N 32-bit image one output row at a time:
- issues row-read commands to the read DMA into a 3-slot line buffer;
- starts the compute unit on the three resident rows;
- issues row-write commands to the write DMA;
- rotates line-buffer slots so each input row is fetched exactly once.

## Interface
Parameters: none (fixed 32-bit words, 3 line-buffer slots).

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- STENCIL_GO  in  1  level start request from register block.
- STENCIL_SIZE  in  16  image dimension N (rows = columns = N).
- STENCIL_SRC  in  32  source image byte address (row 0).
- STENCIL_DST  in  32  destination image byte address (row 0).
- STENCIL_DONE  out  1  run complete; held until GO drops.
- STENCIL_BUSY  out  1  high in every state except IDLE and FIN.
- RD_CMD_VALID  out  1  read command valid.
- RD_CMD_READY  in  1  read DMA accepts command.
- RD_CMD_ADDR  out  32  row byte address.
- RD_CMD_LEN  out  16  words to read (= N).
- RD_CMD_SLOT  out  2  destination line-buffer slot, 0..2.
- RD_DONE  in  1  one-cycle pulse: last word of commanded row written to slot.
- CALC_START  out  1  one-cycle pulse: compute one output row.
- CALC_TOP, CALC_MID, CALC_BOT  out  2 each  slots holding rows r-1, r, r+1.
- CALC_DONE  in  1  one-cycle pulse: output row staged for write DMA.
- WR_CMD_VALID  out  1  write command valid.
- WR_CMD_READY  in  1  write DMA accepts command.
- WR_CMD_ADDR  out  32  destination row byte address.
- WR_CMD_LEN  out  16  words to write (= N).
- WR_DONE  in  1  one-cycle pulse: write response received for commanded row.

## Operation
- Start:
  - go_d registers GO (reset 0). Start condition: state IDLE, GO=1, go_d=0.
  - GO already high when reset releases counts as a start.
- On start, latch the following; the run uses only latched values:
  - N = SIZE;
  - stride = {14'b0, SIZE, 2'b00};
  - rd_addr = SRC;
  - wr_addr = DST + stride.
- If N < 3, go directly to FIN. No commands are issued.
- States: IDLE, RD_ISSUE, RD_WAIT, CALC, CALC_WAIT, WR_ISSUE, WR_WAIT, FIN.
- Prologue:
  - Read rows 0, 1, 2 into slots 0, 1, 2 (RD_ISSUE→RD_WAIT each).
  - rd_cnt counts reads; while rd_cnt < 3 after RD_DONE, return to RD_ISSUE; otherwise go to CALC.
- Per output row r = 1..N-2:
  - CALC: pulse CALC_START with slots top/mid/bot, then wait in CALC_WAIT for CALC_DONE.
  - WR_ISSUE, then wait in WR_WAIT for WR_DONE.
  - After WR_DONE: if r = N-2, go to FIN. Otherwise:
    - rotate slots: top←mid, mid←bot, bot←old top;
    - r←r+1;
    - read row r+2 into the new bot slot (RD_ISSUE, RD_WAIT);
    - go to CALC.
- Totals per run: N reads, N-2 calcs, N-2 writes. Rows 0 and N-1 of DST are never written.
- Address arithmetic:
  - rd_addr += stride on each read handshake; wr_addr += stride on each write handshake.
  - All additions are modulo 2^32 (wrap silently).
- Slot registers reset to top=0, mid=1, bot=2, and are re-initialised to these values at each start.
- FIN: STENCIL_DONE=1. Go to IDLE in the cycle GO is sampled 0. If GO is already 0 on entry, DONE is high for exactly one cycle.
- GO changes during a run are ignored. A new run needs GO to be seen low, then high.
- RD_DONE, CALC_DONE, WR_DONE are acted on only in their own WAIT state. Pulses in any other state are ignored.

## Timing
- Reset: ARESET high at a rising edge forces all of the following on the next cycle, regardless of state (mid-run included):
  - state=IDLE, go_d=0;
  - all VALID, CALC_START, DONE, BUSY = 0;
  - ADDR/LEN/SLOT = 0;
  - counters = 0;
  - slots = 0/1/2.
  In-flight DMA transfers are not cancelled by this block.
- Start latency:
  - Start sampled at edge k → RD_CMD_VALID=1 and BUSY=1 from cycle k+1.
  - When N < 3: DONE=1 from cycle k+1.
- Command handshake (RD and WR identical):
  - VALID, ADDR, LEN, SLOT are registered and stable while VALID=1 and READY=0.
  - Transfer occurs at the edge where VALID&READY=1; VALID is 0 the next cycle.
  - VALID never depends combinationally on READY.
- CALC_START is high for exactly one cycle: the cycle after entering CALC. CALC_TOP/MID/BOT are stable from CALC_START until CALC_DONE.
- A done pulse arriving in the same cycle its command handshakes is not possible: the done pulse is ignored, because the FSM is not yet in the WAIT state.
- Minimum per-row overhead: 1 cycle for each of issue, calc and FIN/IDLE transitions, plus external latencies.

## Test plan
- N=5, SRC=0x1000, DST=0x8000, all READY=1, done pulses 3 cycles after each command:
  - reads at 0x1000/0x1014/0x1028/0x103C/0x1050 into slots 0/1/2/0/1, LEN=5;
  - calcs (0,1,2), (1,2,0), (2,0,1);
  - writes at 0x8014/0x8028/0x803C;
  - DONE then held until GO=0, then IDLE.
- N=2 and N=0: GO rise → DONE=1 next cycle, no VALID or CALC_START ever asserted, BUSY stays 0.
- Backpressure: hold RD_CMD_READY=0 for 10 cycles and WR_CMD_READY=0 for 7 cycles → VALID, ADDR, LEN, SLOT unchanged across the stall, exactly one transfer each.
- Stray pulses: RD_DONE/CALC_DONE/WR_DONE injected in the wrong state, and GO toggled mid-run → no state change, command counts still N/N-2/N-2.
- Wrap: SRC=0xFFFFFFF0, N=3 → read addresses 0xFFFFFFF0, 0xFFFFFFFC, 0x00000008.
- ARESET asserted in CALC_WAIT of row 2 → all outputs reset next cycle. With GO held 1 through reset, a new run starts after release, at rd_addr=SRC with slots 0/1/2.

Source files
------------

// File: rtl/stencil_seq.sv
// Row-level sequencer for the stencil coprocessor: streams an NxN image through a
// 3-slot line buffer, one read per input row and one calc + write per inner output row.
module stencil_seq (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        STENCIL_GO,
  input  logic [15:0] STENCIL_SIZE,
  input  logic [31:0] STENCIL_SRC,
  input  logic [31:0] STENCIL_DST,
  output logic        STENCIL_DONE,
  output logic        STENCIL_BUSY,
  output logic        RD_CMD_VALID,
  input  logic        RD_CMD_READY,
  output logic [31:0] RD_CMD_ADDR,
  output logic [15:0] RD_CMD_LEN,
  output logic [1:0]  RD_CMD_SLOT,
  input  logic        RD_DONE,
  output logic        CALC_START,
  output logic [1:0]  CALC_TOP,
  output logic [1:0]  CALC_MID,
  output logic [1:0]  CALC_BOT,
  input  logic        CALC_DONE,
  output logic        WR_CMD_VALID,
  input  logic        WR_CMD_READY,
  output logic [31:0] WR_CMD_ADDR,
  output logic [15:0] WR_CMD_LEN,
  input  logic        WR_DONE
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, CALC, CALC_WAIT, WR_ISSUE, WR_WAIT, FIN
  } state_t;

  state_t      state_reg, state_next;
  logic        go_d_reg;
  logic [15:0] n_reg, rd_cnt_reg, row_reg;
  logic [31:0] stride_reg, rd_addr_reg, wr_addr_reg;
  logic [1:0]  top_reg, mid_reg, bot_reg;
  logic        start;
  logic        last_row;
  logic [31:0] size_stride;

  assign start       = (state_reg == IDLE) && STENCIL_GO && !go_d_reg;
  assign size_stride = {14'b0, STENCIL_SIZE, 2'b00};
  assign last_row    = (row_reg == n_reg - 16'd2);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = (STENCIL_SIZE < 16'd3) ? FIN : RD_ISSUE;
      RD_ISSUE:  if (RD_CMD_READY) state_next = RD_WAIT;
      // The first three reads fill the buffer; later reads feed exactly one calc each.
      RD_WAIT:   if (RD_DONE) state_next = (rd_cnt_reg < 16'd3) ? RD_ISSUE : CALC;
      CALC:      state_next = CALC_WAIT;
      CALC_WAIT: if (CALC_DONE) state_next = WR_ISSUE;
      WR_ISSUE:  if (WR_CMD_READY) state_next = WR_WAIT;
      WR_WAIT:   if (WR_DONE) state_next = last_row ? FIN : RD_ISSUE;
      FIN:       if (!STENCIL_GO) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      go_d_reg    <= 1'b0;
      n_reg       <= '0;
      rd_cnt_reg  <= '0;
      row_reg     <= '0;
      stride_reg  <= '0;
      rd_addr_reg <= '0;
      wr_addr_reg <= '0;
      top_reg     <= 2'd0;
      mid_reg     <= 2'd1;
      bot_reg     <= 2'd2;
    end else begin
      state_reg <= state_next;
      go_d_reg  <= STENCIL_GO;
      if (start) begin
        n_reg       <= STENCIL_SIZE;
        stride_reg  <= size_stride;
        rd_addr_reg <= STENCIL_SRC;
        wr_addr_reg <= STENCIL_DST + size_stride;
        rd_cnt_reg  <= '0;
        row_reg     <= 16'd1;
        top_reg     <= 2'd0;
        mid_reg     <= 2'd1;
        bot_reg     <= 2'd2;
      end
      if (state_reg == RD_ISSUE && RD_CMD_READY) begin
        rd_addr_reg <= rd_addr_reg + stride_reg;
        rd_cnt_reg  <= rd_cnt_reg + 16'd1;
      end
      if (state_reg == WR_ISSUE && WR_CMD_READY)
        wr_addr_reg <= wr_addr_reg + stride_reg;
      // The oldest row (top) is no longer needed, so its slot receives row r+2.
      if (state_reg == WR_WAIT && WR_DONE && !last_row) begin
        top_reg <= mid_reg;
        mid_reg <= bot_reg;
        bot_reg <= top_reg;
        row_reg <= row_reg + 16'd1;
      end
    end
  end

  always_comb begin
    RD_CMD_VALID = (state_reg == RD_ISSUE);
    RD_CMD_ADDR  = RD_CMD_VALID ? rd_addr_reg : '0;
    RD_CMD_LEN   = RD_CMD_VALID ? n_reg : '0;
    RD_CMD_SLOT  = '0;
    if (RD_CMD_VALID)
      RD_CMD_SLOT = (rd_cnt_reg < 16'd3) ? rd_cnt_reg[1:0] : bot_reg;
    WR_CMD_VALID = (state_reg == WR_ISSUE);
    WR_CMD_ADDR  = WR_CMD_VALID ? wr_addr_reg : '0;
    WR_CMD_LEN   = WR_CMD_VALID ? n_reg : '0;
    CALC_START   = (state_reg == CALC);
    CALC_TOP     = top_reg;
    CALC_MID     = mid_reg;
    CALC_BOT     = bot_reg;
    STENCIL_DONE = (state_reg == FIN);
    STENCIL_BUSY = (state_reg != IDLE) && (state_reg != FIN);
  end

endmodule

// File: tb/tb_stencil_seq.sv
// Bench for stencil_seq: emulated DMA/compute responders record every command,
// and each run is compared with the row/slot/address sequence expected for N, SRC, DST.
module tb_stencil_seq;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        STENCIL_GO;
  logic [15:0] STENCIL_SIZE;
  logic [31:0] STENCIL_SRC, STENCIL_DST;
  logic        STENCIL_DONE, STENCIL_BUSY;
  logic        RD_CMD_VALID, RD_CMD_READY, RD_DONE;
  logic [31:0] RD_CMD_ADDR;
  logic [15:0] RD_CMD_LEN;
  logic [1:0]  RD_CMD_SLOT;
  logic        CALC_START, CALC_DONE;
  logic [1:0]  CALC_TOP, CALC_MID, CALC_BOT;
  logic        WR_CMD_VALID, WR_CMD_READY, WR_DONE;
  logic [31:0] WR_CMD_ADDR;
  logic [15:0] WR_CMD_LEN;

  stencil_seq dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .STENCIL_GO(STENCIL_GO), .STENCIL_SIZE(STENCIL_SIZE),
    .STENCIL_SRC(STENCIL_SRC), .STENCIL_DST(STENCIL_DST),
    .STENCIL_DONE(STENCIL_DONE), .STENCIL_BUSY(STENCIL_BUSY),
    .RD_CMD_VALID(RD_CMD_VALID), .RD_CMD_READY(RD_CMD_READY),
    .RD_CMD_ADDR(RD_CMD_ADDR), .RD_CMD_LEN(RD_CMD_LEN), .RD_CMD_SLOT(RD_CMD_SLOT),
    .RD_DONE(RD_DONE),
    .CALC_START(CALC_START), .CALC_TOP(CALC_TOP), .CALC_MID(CALC_MID),
    .CALC_BOT(CALC_BOT), .CALC_DONE(CALC_DONE),
    .WR_CMD_VALID(WR_CMD_VALID), .WR_CMD_READY(WR_CMD_READY),
    .WR_CMD_ADDR(WR_CMD_ADDR), .WR_CMD_LEN(WR_CMD_LEN), .WR_DONE(WR_DONE)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Responder controls and transaction logs
  bit rnd_mode = 1'b0;
  bit stray_en = 1'b0;
  int rd_cd = 0, calc_cd = 0, wr_cd = 0;
  int rd_stall_req = 0, rd_stall_left = 0;
  int wr_stall_req = 0, wr_stall_left = 0;
  logic [31:0] rd_cap_addr, wr_cap_addr;
  logic [15:0] rd_cap_len, wr_cap_len;
  logic [1:0]  rd_cap_slot;
  int activity = 0;
  logic [31:0] rd_addr_q[$], rd_len_q[$], rd_slot_q[$], calc_q[$], wr_addr_q[$], wr_len_q[$];

  function automatic int lat();
    return rnd_mode ? int'($urandom_range(1, 5)) : 3;
  endfunction

  function automatic logic stray();
    return stray_en && ($urandom_range(0, 7) == 0);
  endfunction

  always @(negedge ACLK) begin
    if (ARESET) begin
      rd_cd = 0; calc_cd = 0; wr_cd = 0; rd_stall_left = 0; wr_stall_left = 0;
      RD_CMD_READY = 1'b0; WR_CMD_READY = 1'b0;
      RD_DONE = 1'b0; CALC_DONE = 1'b0; WR_DONE = 1'b0;
    end else begin
      if (RD_CMD_VALID || WR_CMD_VALID || CALC_START || STENCIL_BUSY) activity++;
      // Done pulses: real ones after a latency, strays only when nothing is outstanding
      RD_DONE = 1'b0;
      if (rd_cd > 0) begin rd_cd--; RD_DONE = (rd_cd == 0); end
      else RD_DONE = stray();
      CALC_DONE = 1'b0;
      if (calc_cd > 0) begin
        calc_cd--;
        CALC_DONE = (calc_cd == 0);
        if (CALC_DONE) check("calc_slots_stable", {26'b0, CALC_TOP, CALC_MID, CALC_BOT}, calc_q[$]);
      end else CALC_DONE = stray();
      WR_DONE = 1'b0;
      if (wr_cd > 0) begin wr_cd--; WR_DONE = (wr_cd == 0); end
      else WR_DONE = stray();
      // Read command channel
      if (rd_stall_left > 0) begin
        check("rd_stall_valid", RD_CMD_VALID, 1);
        check("rd_stall_addr", RD_CMD_ADDR, rd_cap_addr);
        check("rd_stall_len", RD_CMD_LEN, rd_cap_len);
        check("rd_stall_slot", RD_CMD_SLOT, rd_cap_slot);
        rd_stall_left--;
        RD_CMD_READY = 1'b0;
      end else if (RD_CMD_VALID && rd_stall_req > 0) begin
        rd_cap_addr = RD_CMD_ADDR; rd_cap_len = RD_CMD_LEN; rd_cap_slot = RD_CMD_SLOT;
        rd_stall_left = rd_stall_req - 1;
        rd_stall_req = 0;
        RD_CMD_READY = 1'b0;
      end else RD_CMD_READY = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (RD_CMD_VALID && RD_CMD_READY) begin
        rd_addr_q.push_back(RD_CMD_ADDR);
        rd_len_q.push_back({16'b0, RD_CMD_LEN});
        rd_slot_q.push_back({30'b0, RD_CMD_SLOT});
        rd_cd = lat();
      end
      // Compute unit
      if (CALC_START) begin
        calc_q.push_back({26'b0, CALC_TOP, CALC_MID, CALC_BOT});
        calc_cd = lat();
      end
      // Write command channel
      if (wr_stall_left > 0) begin
        check("wr_stall_valid", WR_CMD_VALID, 1);
        check("wr_stall_addr", WR_CMD_ADDR, wr_cap_addr);
        check("wr_stall_len", WR_CMD_LEN, wr_cap_len);
        wr_stall_left--;
        WR_CMD_READY = 1'b0;
      end else if (WR_CMD_VALID && wr_stall_req > 0) begin
        wr_cap_addr = WR_CMD_ADDR; wr_cap_len = WR_CMD_LEN;
        wr_stall_left = wr_stall_req - 1;
        wr_stall_req = 0;
        WR_CMD_READY = 1'b0;
      end else WR_CMD_READY = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (WR_CMD_VALID && WR_CMD_READY) begin
        wr_addr_q.push_back(WR_CMD_ADDR);
        wr_len_q.push_back({16'b0, WR_CMD_LEN});
        wr_cd = lat();
      end
    end
  end

  task automatic clear_q();
    rd_addr_q.delete(); rd_len_q.delete(); rd_slot_q.delete();
    calc_q.delete(); wr_addr_q.delete(); wr_len_q.delete();
  endtask

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  // Reference: row k lives in slot k%3; output row r reads rows r-1..r+1, writes DST+r*stride.
  task automatic compare(input int n, input logic [31:0] src, input logic [31:0] dst);
    int nr = (n >= 3) ? n : 0;
    int nc = (n >= 3) ? n - 2 : 0;
    logic [31:0] stride = 32'(n) << 2;
    check("rd_count", rd_addr_q.size(), nr);
    check("calc_count", calc_q.size(), nc);
    check("wr_count", wr_addr_q.size(), nc);
    for (int i = 0; i < nr && i < rd_addr_q.size(); i++) begin
      check("rd_addr", rd_addr_q[i], src + 32'(i) * stride);
      check("rd_len", rd_len_q[i], 32'(n));
      check("rd_slot", rd_slot_q[i], 32'(i % 3));
    end
    for (int r = 1; r <= nc && r <= calc_q.size(); r++)
      check("calc_slots", calc_q[r-1], 32'(((r - 1) % 3) * 16 + (r % 3) * 4 + ((r + 1) % 3)));
    for (int r = 1; r <= nc && r <= wr_addr_q.size(); r++) begin
      check("wr_addr", wr_addr_q[r-1], dst + 32'(r) * stride);
      check("wr_len", wr_len_q[r-1], 32'(n));
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && !STENCIL_DONE; i++) tick();
    check("run_done", STENCIL_DONE, 1);
  endtask

  task automatic finish_run(input int n, input logic [31:0] src, input logic [31:0] dst);
    wait_done();
    for (int i = 0; i < 3; i++) begin
      check("done_held", STENCIL_DONE, 1);
      check("busy_in_fin", STENCIL_BUSY, 0);
      tick();
    end
    STENCIL_GO = 1'b0;
    tick();
    check("done_clear", STENCIL_DONE, 0);
    check("idle_busy", STENCIL_BUSY, 0);
    compare(n, src, dst);
    if (n < 3) check("no_activity", activity, 0);
  endtask

  task automatic run(input int n, input logic [31:0] src, input logic [31:0] dst, input bit toggle);
    $display("run n=%0d src=%h dst=%h toggle=%0d", n, src, dst, toggle);
    clear_q();
    activity = 0;
    STENCIL_SIZE = 16'(n); STENCIL_SRC = src; STENCIL_DST = dst;
    tick();
    STENCIL_GO = 1'b1;
    tick();
    // Run must use latched values only
    STENCIL_SIZE = 16'($urandom); STENCIL_SRC = $urandom; STENCIL_DST = $urandom;
    if (n < 3) begin
      check("short_done", STENCIL_DONE, 1);
      check("short_busy", STENCIL_BUSY, 0);
      check("short_valid", RD_CMD_VALID, 0);
    end else begin
      check("start_valid", RD_CMD_VALID, 1);
      check("start_busy", STENCIL_BUSY, 1);
      check("start_addr", RD_CMD_ADDR, src);
      check("start_done", STENCIL_DONE, 0);
    end
    if (toggle) begin
      repeat (2) tick();
      STENCIL_GO = 1'b0;
      repeat (2) tick();
      STENCIL_GO = 1'b1;
    end
    finish_run(n, src, dst);
  endtask

  task automatic reset_test();
    $display("run reset-midrun n=6 src=00002000 dst=00009000");
    clear_q();
    STENCIL_SIZE = 16'd6; STENCIL_SRC = 32'h2000; STENCIL_DST = 32'h9000;
    tick();
    STENCIL_GO = 1'b1;
    for (int i = 0; i < 2000 && calc_q.size() < 2; i++) tick();
    check("rst_reach_calc2", calc_q.size(), 2);
    ARESET = 1'b1;
    tick();
    check("rst_rd_valid", RD_CMD_VALID, 0);
    check("rst_wr_valid", WR_CMD_VALID, 0);
    check("rst_calc_start", CALC_START, 0);
    check("rst_done", STENCIL_DONE, 0);
    check("rst_busy", STENCIL_BUSY, 0);
    check("rst_rd_addr", RD_CMD_ADDR, 0);
    check("rst_rd_len", RD_CMD_LEN, 0);
    check("rst_rd_slot", RD_CMD_SLOT, 0);
    check("rst_wr_addr", WR_CMD_ADDR, 0);
    check("rst_wr_len", WR_CMD_LEN, 0);
    check("rst_slots", {CALC_TOP, CALC_MID, CALC_BOT}, 32'h06);
    clear_q();
    ARESET = 1'b0;
    tick();
    check("restart_valid", RD_CMD_VALID, 1);
    check("restart_addr", RD_CMD_ADDR, 32'h2000);
    check("restart_slot", RD_CMD_SLOT, 0);
    finish_run(6, 32'h2000, 32'h9000);
  endtask

  initial begin
    ARESET = 1'b1;
    STENCIL_GO = 1'b0;
    STENCIL_SIZE = '0; STENCIL_SRC = '0; STENCIL_DST = '0;
    RD_CMD_READY = 1'b0; WR_CMD_READY = 1'b0;
    RD_DONE = 1'b0; CALC_DONE = 1'b0; WR_DONE = 1'b0;
    repeat (3) tick();
    check("init_done", STENCIL_DONE, 0);
    check("init_busy", STENCIL_BUSY, 0);
    check("init_rd_valid", RD_CMD_VALID, 0);
    check("init_wr_valid", WR_CMD_VALID, 0);
    check("init_calc_start", CALC_START, 0);
    check("init_slots", {CALC_TOP, CALC_MID, CALC_BOT}, 32'h06);
    ARESET = 1'b0;
    tick();

    run(5, 32'h1000, 32'h8000, 1'b0);
    run(2, 32'h1000, 32'h8000, 1'b0);
    run(0, 32'h1000, 32'h8000, 1'b0);
    run(3, 32'hFFFF_FFF0, 32'h0000_0100, 1'b0);
    rd_stall_req = 10;
    wr_stall_req = 7;
    run(4, 32'h4000, 32'h5000, 1'b0);

    rnd_mode = 1'b1;
    stray_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n = int'($urandom_range(0, 10));
      run(n, $urandom, $urandom, (n >= 3) && ($urandom_range(0, 1) == 1));
    end

    rnd_mode = 1'b0;
    stray_en = 1'b0;
    reset_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
